// File: rtl/shift_if.sv
// Command/data bundle between a datapath master and shift_engine.
// The master drives commands and load data; the engine returns register state and burst handshake.
interface shift_if #(
    parameter int N = 8,
    parameter int S = 1
);
    logic [2:0]   mode;
    logic         start;
    logic         burst_dir;
    logic [N-1:0] parallel_in;
    logic [S-1:0] ser_in;
    logic [N-1:0] parallel_out;
    logic [S-1:0] ser_out;
    logic         busy;
    logic         done;

    modport master (
        output mode, start, burst_dir, parallel_in, ser_in,
        input  parallel_out, ser_out, busy, done
    );

    modport slave (
        input  mode, start, burst_dir, parallel_in, ser_in,
        output parallel_out, ser_out, busy, done
    );
endinterface

// File: rtl/shift_engine.sv
// Universal S-bit-step shift register with manual modes and an autonomous N/S-cycle burst serializer.
// All outputs are registered; reset is synchronous and active high.
module shift_engine #(
    parameter int N = 8,
    parameter int S = 1
) (
    input  logic   clk,
    input  logic   rst,
    shift_if.slave bus
);
    localparam int STEPS = N / S;
    localparam int CW    = $clog2(STEPS + 1);

    generate
        if (N < 2 || S < 1 || S >= N || (N % S) != 0) begin : g_bad_params
            $error("shift_engine: need N >= 2, 1 <= S < N and N %% S == 0");
        end
    endgenerate

    typedef enum logic {IDLE, BURST} state_t;

    state_t       state;
    logic [CW-1:0] cnt;
    logic         dir_q;
    logic [N-1:0] po;
    logic [S-1:0] so;
    logic         busy_q;
    logic         done_q;

    assign bus.parallel_out = po;
    assign bus.ser_out      = so;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

    // Candidate next values shared by manual modes and the burst path.
    logic [N-1:0] lsr, lsl, rotr, rotl, asr;
    logic [S-1:0] lo_bits, hi_bits;

    always_comb begin
        lsr     = {bus.ser_in, po[N-1:S]};
        lsl     = {po[N-S-1:0], bus.ser_in};
        rotr    = {po[S-1:0], po[N-1:S]};
        rotl    = {po[N-S-1:0], po[N-1:N-S]};
        asr     = {{S{po[N-1]}}, po[N-1:S]};
        lo_bits = po[S-1:0];
        hi_bits = po[N-1:N-S];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dir_q  <= 1'b0;
            po     <= '0;
            so     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        po     <= bus.parallel_in;
                        so     <= '0;
                        dir_q  <= bus.burst_dir;
                        cnt    <= CW'(STEPS);
                        busy_q <= 1'b1;
                        state  <= BURST;
                    end else begin
                        case (bus.mode)
                            3'b001: begin po <= lsr;             so <= lo_bits; end
                            3'b010: begin po <= lsl;             so <= hi_bits; end
                            3'b011: begin po <= bus.parallel_in; so <= '0;      end
                            3'b100: begin po <= rotr;            so <= lo_bits; end
                            3'b101: begin po <= rotl;            so <= hi_bits; end
                            3'b110: begin po <= asr;             so <= lo_bits; end
                            default: so <= '0;
                        endcase
                    end
                end
                BURST: begin
                    // dir_q = 1 streams LSB first (shift right), otherwise MSB first.
                    if (dir_q) begin
                        po <= lsr;
                        so <= lo_bits;
                    end else begin
                        po <= lsl;
                        so <= hi_bits;
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench: two engines (N=8,S=1 and N=8,S=2) against a cycle-level arithmetic model,
// with directed scenarios followed by randomized traffic.
module tb_shift_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic       start;
    logic       bdir;
    logic [7:0] pin;
    logic       sin8;
    logic [1:0] sin2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    shift_if #(.N(8), .S(1)) if8 ();
    shift_if #(.N(8), .S(2)) if2 ();

    assign if8.mode        = mode;
    assign if8.start       = start;
    assign if8.burst_dir   = bdir;
    assign if8.parallel_in = pin;
    assign if8.ser_in      = sin8;
    assign if2.mode        = mode;
    assign if2.start       = start;
    assign if2.burst_dir   = bdir;
    assign if2.parallel_in = pin;
    assign if2.ser_in      = sin2;

    shift_engine #(.N(8), .S(1)) u_s1 (.clk(clk), .rst(rst), .bus(if8));
    shift_engine #(.N(8), .S(2)) u_s2 (.clk(clk), .rst(rst), .bus(if2));

    // Model: rem counts remaining burst shifts; rem == 0 means idle.
    typedef struct {
        int unsigned po;
        int unsigned so;
        int unsigned rem;
        bit          busy;
        bit          done;
        bit          dir;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t step(mdl_t m, int n, int s, bit r, int unsigned md, bit st,
                                  bit bd, int unsigned p, int unsigned si);
        int unsigned mask  = (1 << n) - 1;
        int unsigned smask = (1 << s) - 1;
        int unsigned lo    = m.po & smask;
        int unsigned hi    = m.po >> (n - s);
        mdl_t x = m;
        x.done = 0;
        if (r) begin
            x.po = 0; x.so = 0; x.rem = 0; x.busy = 0; x.dir = 0;
            return x;
        end
        if (m.rem == 0) begin
            if (st) begin
                x.po = p & mask; x.so = 0; x.dir = bd; x.rem = n / s; x.busy = 1;
            end else begin
                case (md)
                    1: begin x.so = lo; x.po = (m.po >> s) | (si << (n - s)); end
                    2: begin x.so = hi; x.po = ((m.po << s) | si) & mask; end
                    3: begin x.so = 0;  x.po = p & mask; end
                    4: begin x.so = lo; x.po = (m.po >> s) | (lo << (n - s)); end
                    5: begin x.so = hi; x.po = ((m.po << s) | hi) & mask; end
                    6: begin
                        x.so = lo;
                        x.po = (m.po >> s) | ((m.po >> (n - 1)) != 0 ? (mask & ~(mask >> s)) : 0);
                    end
                    default: x.so = 0;
                endcase
            end
        end else begin
            if (m.dir) begin x.so = lo; x.po = (m.po >> s) | (si << (n - s)); end
            else       begin x.so = hi; x.po = ((m.po << s) | si) & mask; end
            x.rem = m.rem - 1;
            if (x.rem == 0) begin x.busy = 0; x.done = 1; end
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare both engines just after it.
    task automatic cyc();
        @(posedge clk);
        m1 = step(m1, 8, 1, rst, mode, start, bdir, pin, sin8);
        m2 = step(m2, 8, 2, rst, mode, start, bdir, pin, sin2);
        #1;
        check("s1_po",   if8.parallel_out, m1.po);
        check("s1_so",   if8.ser_out,      m1.so);
        check("s1_busy", if8.busy,         m1.busy);
        check("s1_done", if8.done,         m1.done);
        check("s2_po",   if2.parallel_out, m2.po);
        check("s2_so",   if2.ser_out,      m2.so);
        check("s2_busy", if2.busy,         m2.busy);
        check("s2_done", if2.done,         m2.done);
    endtask

    initial begin
        int bc, dc;
        logic [7:0] seq8;
        logic [1:0] seq2 [4];
        m1 = '{po: 0, so: 0, rem: 0, busy: 0, done: 0, dir: 0};
        m2 = m1;

        // Reset dominates start and load
        rst = 1; start = 1; mode = 3'b011; pin = 8'hFF; bdir = 0; sin8 = 0; sin2 = 0;
        cyc(); cyc();
        check("rst_po",   if8.parallel_out, 8'h00);
        check("rst_so",   if8.ser_out,      1'b0);
        check("rst_busy", if8.busy,         1'b0);
        check("rst_done", if8.done,         1'b0);
        rst = 0; start = 0;

        // Rotates
        mode = 3'b011; pin = 8'hA5; cyc();
        mode = 3'b101; cyc();
        check("rotl_po", if8.parallel_out, 8'h4B);
        check("rotl_so", if8.ser_out,      1'b1);
        mode = 3'b011; cyc();
        mode = 3'b100; cyc();
        check("rotr_po", if8.parallel_out, 8'hD2);
        check("rotr_so", if8.ser_out,      1'b1);

        // Shifts
        mode = 3'b011; pin = 8'h90; cyc();
        mode = 3'b110; sin8 = 1; cyc();
        check("asr_po", if8.parallel_out, 8'hC8);
        check("asr_so", if8.ser_out,      1'b0);
        mode = 3'b011; cyc();
        mode = 3'b001; sin8 = 0; cyc();
        check("lsr_po", if8.parallel_out, 8'h48);
        mode = 3'b011; cyc();
        mode = 3'b010; sin8 = 1; cyc();
        check("lsl_po", if8.parallel_out, 8'h21);
        check("lsl_so", if8.ser_out,      1'b1);

        // Burst MSB-first, S=1, with mode/start/data noise during the burst
        mode = 3'b000; pin = 8'hB4; bdir = 0; sin8 = 0; start = 1; cyc();
        check("b1_load", if8.parallel_out, 8'hB4);
        bc = if8.busy ? 1 : 0;
        seq8 = 8'b1011_0100;
        for (int i = 0; i < 8; i++) begin
            mode = 3'($urandom); start = 1'($urandom); pin = 8'($urandom); bdir = 1'($urandom);
            cyc();
            check("b1_bit",  if8.ser_out, seq8[7 - i]);
            check("b1_done", if8.done,    (i == 7) ? 1'b1 : 1'b0);
            if (if8.busy) bc++;
        end
        check("b1_busy_len", bc, 8);
        check("b1_final",    if8.parallel_out, 8'h00);

        // Burst LSB-first, S=2, start held through the done cycle
        start = 0; mode = 3'b000; cyc(); cyc(); cyc(); cyc(); cyc(); cyc(); cyc(); cyc(); cyc();
        pin = 8'hB4; bdir = 1; sin2 = 2'b11; start = 1; cyc();
        seq2[0] = 2'b00; seq2[1] = 2'b01; seq2[2] = 2'b11; seq2[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("b2_bits", if2.ser_out, seq2[i]);
            check("b2_busy", if2.busy, (i < 3) ? 1'b1 : 1'b0);
            check("b2_done", if2.done, (i == 3) ? 1'b1 : 1'b0);
        end
        check("b2_final", if2.parallel_out, 8'hFF);
        cyc();
        check("b2_reload_po",   if2.parallel_out, 8'hB4);
        check("b2_reload_busy", if2.busy,         1'b1);
        start = 0;
        for (int i = 0; i < 9; i++) cyc();

        // Reset mid-burst, then a clean full burst
        pin = 8'hC3; bdir = 0; sin8 = 1; start = 1; cyc();
        start = 0; cyc(); cyc(); cyc();
        rst = 1; cyc();
        check("mid_rst_po",   if8.parallel_out, 8'h00);
        check("mid_rst_busy", if8.busy,         1'b0);
        rst = 0; cyc();
        check("mid_rst_nodone", if8.done, 1'b0);
        start = 1; cyc();
        start = 0;
        bc = if8.busy ? 1 : 0; dc = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (if8.busy) bc++;
            if (if8.done) dc++;
        end
        check("post_rst_busy_len", bc, 8);
        check("post_rst_done_cnt", dc, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(31) == 0);
            start = ($urandom_range(7) == 0);
            mode  = 3'($urandom);
            bdir  = 1'($urandom);
            pin   = 8'($urandom);
            sin8  = 1'($urandom);
            sin2  = 2'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised universal shift register with S-bit shift step, logical/rotate/arithmetic modes and an autonomous burst serializer. A single command shifts a full N-bit word out over N/S cycles with busy/done handshaking. It sits between parallel datapath registers and serial links (bit-banged SPI/UART-style transmit and receive), replacing the fixed 1-bit, 4-mode shift register in new designs.

## Interface
Parameters:
- N, default 8: register width; N ≥ 2.
- S, default 1: shift step in bits; 1 ≤ S < N; N % S == 0 (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset; one clock, reset sampled on rising edge of clk.
- mode  in  3  manual command, IDLE only. 000 hold, 001 logical shift right, 010 logical shift left, 011 parallel load, 100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 hold (reserved).
- start  in  1  begin burst; sampled in IDLE only.
- burst_dir  in  1  sampled with start. 0 = MSB-first (shift left), 1 = LSB-first (shift right).
- parallel_in  in  N  load data for mode 011 and for burst start.
- ser_in  in  S  bits shifted into the vacated end (logical shifts and burst).
- parallel_out  out  N  register contents.
- ser_out  out  S  bits shifted/rotated out by the last edge; 0 otherwise.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the final burst shift.

## Operation
- FSM: IDLE, BURST. Internal counter cnt, width $clog2(N/S+1). Latched direction dir_q.
- Reset (rst=1 at an edge, any state): parallel_out=0, ser_out=0, busy=0, done=0, cnt=0, state=IDLE. Reset has priority over everything.
- IDLE, start=0: mode applied each edge.
  - 000/111: parallel_out held, ser_out<=0.
  - 001: parallel_out<={ser_in, parallel_out[N-1:S]}, ser_out<=parallel_out[S-1:0].
  - 010: parallel_out<={parallel_out[N-S-1:0], ser_in}, ser_out<=parallel_out[N-1:N-S].
  - 011: parallel_out<=parallel_in, ser_out<=0.
  - 100: rotate right by S, ser_out<=parallel_out[S-1:0].
  - 101: rotate left by S, ser_out<=parallel_out[N-1:N-S].
  - 110: shift right by S, vacated bits filled with parallel_out[N-1]. ser_in ignored. ser_out<=parallel_out[S-1:0].
- IDLE, start=1: start has priority over mode. parallel_out<=parallel_in, ser_out<=0, dir_q<=burst_dir, cnt<=N/S, busy<=1, state<=BURST.
- BURST: each edge performs a logical shift by S in dir_q direction (as 010 for dir 0, 001 for dir 1), inserts ser_in and emits ser_out. cnt decrements.
  - On the edge where cnt==1: busy<=0, done<=1, state<=IDLE.
- In BURST, mode, start, burst_dir and parallel_in are ignored.
- done is 0 on every edge except the one that ends a burst.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Manual modes: result visible one edge after command sampled.
- Burst: start sampled at edge k → load visible after k. Shifts at edges k+1..k+N/S. ser_out valid after each of those edges. busy high after edges k..k+N/S-1 (exactly N/S cycles). done high for the one cycle after edge k+N/S.
- Back-to-back: start asserted during the done cycle is accepted (state already IDLE). The next load occurs at that edge with no gap cycle.
- rst mid-burst: abort at that edge. No done pulse. Next start accepted on the following edge.

## Test plan
- Reset: drive start=1, mode=011, parallel_in=0xFF with rst=1 for 2 edges → parallel_out=0x00, ser_out=0, busy=0, done=0.
- Rotates (N=8,S=1): load 0xA5; rotate left → 0x4B, ser_out=1. Reload 0xA5; rotate right → 0xD2, ser_out=1.
- Shifts (N=8,S=1):
  - Load 0x90; arithmetic right → 0xC8, ser_out=0.
  - Reload 0x90; logical right, ser_in=0 → 0x48.
  - Logical left, ser_in=1, from 0x90 → 0x21, ser_out=1.
- Burst MSB-first (N=8,S=1): parallel_in=0xB4, burst_dir=0, ser_in=0, pulse start → ser_out sequence 1,0,1,1,0,1,0,0 on 8 consecutive cycles. busy high exactly 8 cycles. done one cycle, coincident with busy falling. Final parallel_out=0x00. Toggling mode/start during burst has no effect.
- Burst LSB-first, S=2 (N=8): parallel_in=0xB4, burst_dir=1, ser_in=2'b11 → ser_out 00,01,11,10. busy 4 cycles. Final parallel_out=0xFF. Start held during done cycle → second burst loads immediately.
- Reset mid-burst: rst after 3 shifts → all outputs 0, no done pulse. Subsequent start performs a complete 8-cycle burst.
